fdivision_multi: RTL and testbench

Multi-channel, runtime-programmable clock divider: the parametrised successor to the single fixed-N divider used in the traffic-light timing chain. Each of CH channels divides the system clock `Fin` by its own divisor, which software/control logic reloads through a valid/ready port without glitching the output. Each channel has two outputs: a square-wave output (toggle mode) or one-cycle pulse output (pulse mode), and a one-cycle `Tick` strobe usable as a clock enable by downstream counters and the light FSM.

---
 rtl/fdivision_multi.sv | 118 +++++++++++
 tb/tb_fdivision_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fdivision_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor reload.
// Each channel produces a toggle/pulse output and a one-cycle terminal-count tick.
module fdivision_multi #(
   parameter int CH      = 4,
   parameter int W       = 32,
   parameter int DEF_DIV = 10,
   parameter int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           Fin,
   input  logic           Rst,
   input  logic [CH-1:0]  En,
   input  logic           LdValid,
   input  logic [CHW-1:0] LdCh,
   input  logic [W-1:0]   LdDiv,
   input  logic           LdMode,
   output logic           LdReady,
   output logic [CH-1:0]  Fout,
   output logic [CH-1:0]  Tick
);

   localparam logic MODE_TOGGLE = 1'b0;

   logic [W-1:0]  cnt   [CH];
   logic [W-1:0]  dact  [CH];
   logic [W-1:0]  dpend [CH];
   logic [CH-1:0] mact;
   logic [CH-1:0] mpend;
   logic [CH-1:0] pend;
   logic [CH-1:0] term;
   logic [CH-1:0] ld_hit;
   logic [W-1:0]  ld_div;
   logic          ch_pend;
   logic          ch_valid;

   // Out-of-range channel selects are always ready and simply discarded.
   always_comb begin
      ch_pend  = 1'b0;
      ch_valid = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (LdCh == CHW'(i)) begin
            ch_pend  = pend[i];
            ch_valid = 1'b1;
         end
      end
   end

   assign LdReady = ~ch_valid | ~ch_pend;
   assign ld_div  = (LdDiv == '0) ? W'(1) : LdDiv;

   always_comb begin
      term   = '0;
      ld_hit = '0;
      for (int i = 0; i < CH; i++) begin
         term[i]   = (cnt[i] == dact[i] - W'(1));
         ld_hit[i] = LdValid & LdReady & (LdCh == CHW'(i));
      end
   end

   always_ff @(posedge Fin or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < CH; i++) begin
            cnt[i]   <= '0;
            dact[i]  <= W'(DEF_DIV);
            dpend[i] <= W'(DEF_DIV);
         end
         mact  <= '0;
         mpend <= '0;
         pend  <= '0;
         Fout  <= '0;
         Tick  <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (En[i]) begin
               if (term[i]) begin
                  // Terminal always completes under the old mode; pending values
                  // take effect for the period that starts here.
                  cnt[i]  <= '0;
                  Tick[i] <= 1'b1;
                  Fout[i] <= (mact[i] == MODE_TOGGLE) ? ~Fout[i] : 1'b1;
                  if (pend[i]) begin
                     dact[i] <= dpend[i];
                     mact[i] <= mpend[i];
                     pend[i] <= 1'b0;
                  end
               end else begin
                  cnt[i]  <= cnt[i] + W'(1);
                  Tick[i] <= 1'b0;
                  if (mact[i] != MODE_TOGGLE) begin
                     Fout[i] <= 1'b0;
                  end
               end
               if (ld_hit[i]) begin
                  dpend[i] <= ld_div;
                  mpend[i] <= LdMode;
                  pend[i]  <= 1'b1;
               end
            end else begin
               Tick[i] <= 1'b0;
               if (pend[i]) begin
                  dact[i] <= dpend[i];
                  mact[i] <= mpend[i];
                  pend[i] <= 1'b0;
                  cnt[i]  <= '0;
                  Fout[i] <= 1'b0;
               end else if (ld_hit[i]) begin
                  dact[i] <= ld_div;
                  mact[i] <= LdMode;
                  cnt[i]  <= '0;
                  Fout[i] <= 1'b0;
               end else if (mact[i] != MODE_TOGGLE) begin
                  Fout[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fdivision_multi.sv
// Directed bench for fdivision_multi: periods, reloads, freeze, reset and discard.
module tb_fdivision_multi;

   localparam int CH  = 4;
   localparam int W   = 32;
   localparam int CHW = 2;

   logic           Fin = 1'b0;
   logic           Rst;
   logic [CH-1:0]  En;
   logic           LdValid;
   logic [CHW-1:0] LdCh;
   logic [W-1:0]   LdDiv;
   logic           LdMode;
   logic           LdReady;
   logic [CH-1:0]  Fout;
   logic [CH-1:0]  Tick;

   logic [2:0]     en_s;
   logic           ldvalid_s;
   logic [1:0]     ldch_s;
   logic [7:0]     lddiv_s;
   logic           ldmode_s;
   logic           ldready_s;
   logic [2:0]     fout_s;
   logic [2:0]     tick_s;

   int nvec = 0;
   int nmis = 0;
   int n;

   fdivision_multi #(.CH(CH), .W(W), .DEF_DIV(10)) u_dut (
      .Fin(Fin), .Rst(Rst), .En(En), .LdValid(LdValid), .LdCh(LdCh),
      .LdDiv(LdDiv), .LdMode(LdMode), .LdReady(LdReady), .Fout(Fout), .Tick(Tick)
   );

   fdivision_multi #(.CH(3), .W(8), .DEF_DIV(4)) u_small (
      .Fin(Fin), .Rst(Rst), .En(en_s), .LdValid(ldvalid_s), .LdCh(ldch_s),
      .LdDiv(lddiv_s), .LdMode(ldmode_s), .LdReady(ldready_s), .Fout(fout_s), .Tick(tick_s)
   );

   always #5 Fin = ~Fin;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts falling edges until the chosen output reaches lvl; -1 if the budget runs out.
   task automatic wait_sig(input int ch, input bit use_fout, input bit lvl,
                           input int budget, output int cnt_out);
      int k;
      k = 0;
      cnt_out = -1;
      while (cnt_out < 0 && k < budget) begin
         @(negedge Fin);
         k++;
         if ((use_fout ? Fout[ch] : Tick[ch]) == lvl) cnt_out = k;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1; En = '0; LdValid = 1'b0; LdCh = '0; LdDiv = '0; LdMode = 1'b0;
      en_s = '0; ldvalid_s = 1'b0; ldch_s = '0; lddiv_s = '0; ldmode_s = 1'b0;
      repeat (2) @(negedge Fin);
      check("rst_fout", Fout, 0);
      check("rst_tick", Tick, 0);
      check("rst_ready", LdReady, 1);

      // Channel 0 at default divisor 10
      Rst = 1'b0;
      En  = 4'b0001;
      wait_sig(0, 0, 1, 40, n); check("ch0_first_tick", n, 10);
      check("ch0_fout_rise", Fout[0], 1);
      wait_sig(0, 1, 0, 40, n); check("ch0_fout_high_len", n, 10);
      wait_sig(0, 1, 1, 40, n); check("ch0_fout_low_len", n, 10);

      // Channel 1 reload to 3 while enabled, mid-count
      En[1] = 1'b1;
      repeat (4) @(negedge Fin);
      LdValid = 1'b1; LdCh = 2'd1; LdDiv = 3; LdMode = 1'b0;
      #1 check("ch1_ready_idle", LdReady, 1);
      @(negedge Fin);
      LdValid = 1'b0;
      #1 check("ch1_ready_pend", LdReady, 0);
      wait_sig(1, 0, 1, 20, n); check("ch1_old_period_end", n, 5);
      check("ch1_fout_rise", Fout[1], 1);
      #1 check("ch1_ready_after", LdReady, 1);
      wait_sig(1, 1, 0, 20, n); check("ch1_new_high_len", n, 3);
      wait_sig(1, 1, 1, 20, n); check("ch1_new_low_len", n, 3);

      // Channel 2: divisor 0 in pulse mode while disabled, clamps to 1
      LdValid = 1'b1; LdCh = 2'd2; LdDiv = 0; LdMode = 1'b1;
      @(negedge Fin);
      LdValid = 1'b0; LdMode = 1'b0;
      En[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Fin);
         check("ch2_tick_cont", Tick[2], 1);
         check("ch2_fout_cont", Fout[2], 1);
      end
      En[2] = 1'b0;
      @(negedge Fin);
      check("ch2_tick_off", Tick[2], 0);
      check("ch2_fout_off", Fout[2], 0);
      En[2] = 1'b1;

      // Channel 0 load coincident with its terminal
      wait_sig(0, 0, 1, 40, n); check("ch0_sync", n > 0, 1);
      repeat (9) @(negedge Fin);
      LdValid = 1'b1; LdCh = 2'd0; LdDiv = 5; LdMode = 1'b0;
      @(negedge Fin);
      LdValid = 1'b0;
      check("ch0_coinc_tick", Tick[0], 1);
      #1 check("ch0_coinc_pend", LdReady, 0);
      wait_sig(0, 0, 1, 20, n); check("ch0_old_again", n, 10);
      wait_sig(0, 0, 1, 20, n); check("ch0_new_period", n, 5);

      // Channel 3 frozen at cnt 4 for 7 cycles
      En[3] = 1'b1;
      repeat (4) @(negedge Fin);
      En[3] = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge Fin);
         check("ch3_frozen_tick", Tick[3], 0);
      end
      En[3] = 1'b1;
      wait_sig(3, 0, 1, 20, n); check("ch3_resume", n, 6);

      // Reset with a pending load on channel 0
      wait_sig(0, 0, 1, 20, n); check("ch0_sync2", n > 0, 1);
      LdValid = 1'b1; LdCh = 2'd0; LdDiv = 7; LdMode = 1'b0;
      @(negedge Fin);
      LdValid = 1'b0;
      #1 check("ch0_pend_before_rst", LdReady, 0);
      check("tick_before_rst", Tick[2], 1);
      #2 Rst = 1'b1;
      #1;
      check("rst_async_tick", Tick, 0);
      check("rst_async_fout", Fout, 0);
      check("rst_async_ready", LdReady, 1);
      @(negedge Fin);
      Rst = 1'b0;
      En  = 4'b0001;
      #1 check("post_rst_ready", LdReady, 1);
      wait_sig(0, 0, 1, 40, n); check("post_rst_tick1", n, 10);
      wait_sig(0, 0, 1, 40, n); check("post_rst_tick2", n, 10);

      // Out-of-range channel on a 3-channel instance is accepted and dropped
      en_s = 3'b111;
      for (int k = 0; k < 3; k++) begin
         @(negedge Fin);
         check("small_idle", tick_s, 0);
      end
      @(negedge Fin);
      check("small_tick1", tick_s, 7);
      ldvalid_s = 1'b1; ldch_s = 2'd3; lddiv_s = 8'd1; ldmode_s = 1'b1;
      #1 check("small_oor_ready", ldready_s, 1);
      @(negedge Fin);
      ldvalid_s = 1'b0;
      check("small_after_oor", tick_s, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge Fin);
         check("small_gap", tick_s, 0);
      end
      @(negedge Fin);
      check("small_tick2", tick_s, 7);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
